// File: rtl/pmod_ad1_spi_capture.sv
// SPI capture engine for the PMOD AD1: drives CS/SCLK for two AD7476A ADCs and
// shifts in both 12-bit channels at once, publishing them with a valid/ack handshake.
module pmod_ad1_spi_capture #(
  parameter int CLK_DIV      = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        enable,
  input  logic        start,
  input  logic        rd_ack,
  input  logic        clr_overrun,
  input  logic        sdata0,
  input  logic        sdata1,
  output logic        cs_n,
  output logic        sclk,
  output logic [11:0] data0,
  output logic [11:0] data1,
  output logic        data_valid,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_QUIET = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [4:0]  bit_cnt, bit_cnt_nx;
  logic        phase, phase_nx;
  logic        shift_en;
  logic        load;
  logic        cs_n_nx, sclk_nx;
  logic        s0_meta, s0_sync, s1_meta, s1_sync;
  logic [11:0] sh0, sh1;

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_cnt_nx = bit_cnt;
    phase_nx   = phase;
    shift_en   = 1'b0;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx     = 8'd0;
        bit_cnt_nx = 5'd0;
        phase_nx   = 1'b0;
        if (start || enable) state_nx = S_SETUP;
      end
      S_SETUP: begin
        if (cnt == DIV_LAST) begin
          cnt_nx     = 8'd0;
          bit_cnt_nx = 5'd0;
          phase_nx   = 1'b0;
          state_nx   = S_SHIFT;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_nx = 8'd0;
          if (!phase) begin
            // Low phase ends: sclk rises on this edge and both channels are sampled.
            phase_nx   = 1'b1;
            shift_en   = 1'b1;
            bit_cnt_nx = bit_cnt + 5'd1;
          end else begin
            phase_nx = 1'b0;
            if (bit_cnt == 5'd16) state_nx = S_DONE;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_DONE: begin
        load     = 1'b1;
        cnt_nx   = 8'd0;
        state_nx = S_QUIET;
      end
      S_QUIET: begin
        // Counts 0..QUIET_CYCLES so the frame period is 1 + 33*CLK_DIV + 1 + QUIET_CYCLES.
        if (cnt == QUIET_LAST) begin
          cnt_nx   = 8'd0;
          state_nx = enable ? S_SETUP : S_IDLE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    cs_n_nx = !((state_nx == S_SETUP) || (state_nx == S_SHIFT));
    sclk_nx = !((state_nx == S_SHIFT) && !phase_nx);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      bit_cnt <= 5'd0;
      phase   <= 1'b0;
      cs_n    <= 1'b1;
      sclk    <= 1'b1;
      s0_meta <= 1'b0;
      s0_sync <= 1'b0;
      s1_meta <= 1'b0;
      s1_sync <= 1'b0;
      sh0     <= 12'd0;
      sh1     <= 12'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_cnt_nx;
      phase   <= phase_nx;
      cs_n    <= cs_n_nx;
      sclk    <= sclk_nx;
      s0_meta <= sdata0;
      s0_sync <= s0_meta;
      s1_meta <= sdata1;
      s1_sync <= s1_meta;
      // 12-bit registers: the four leading bits of each 16-bit frame fall off the top.
      if (shift_en) begin
        sh0 <= {sh0[10:0], s0_sync};
        sh1 <= {sh1[10:0], s1_sync};
      end
    end
  end

  // Handshake: data_valid rises on a load and stays until rd_ack is seen with no
  // load in the same cycle; a load while valid and unacknowledged sets overrun.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      data0      <= 12'd0;
      data1      <= 12'd0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        data0      <= sh0;
        data1      <= sh1;
        data_valid <= 1'b1;
      end else if (rd_ack) begin
        data_valid <= 1'b0;
      end
      if (load && data_valid && !rd_ack) overrun <= 1'b1;
      else if (clr_overrun)              overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmod_ad1_spi_capture.sv
// Bench for pmod_ad1_spi_capture: ADC model, directed frames, and a scoreboard
// that checks every published sample pair against the queued expectation.
module tb_pmod_ad1_spi_capture;
  localparam int CLK_DIV      = 4;
  localparam int QUIET_CYCLES = 8;
  localparam int LOW_CYCLES   = 132;
  localparam int PERIOD       = 142;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        rd_ack = 1'b0;
  logic        clr_overrun = 1'b0;
  logic        sdata0 = 1'b0;
  logic        sdata1 = 1'b0;
  logic        cs_n, sclk, data_valid, overrun, busy;
  logic [11:0] data0, data1;

  pmod_ad1_spi_capture #(.CLK_DIV(CLK_DIV), .QUIET_CYCLES(QUIET_CYCLES)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .start(start),
    .rd_ack(rd_ack), .clr_overrun(clr_overrun), .sdata0(sdata0), .sdata1(sdata1),
    .cs_n(cs_n), .sclk(sclk), .data0(data0), .data1(data1),
    .data_valid(data_valid), .overrun(overrun), .busy(busy)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  int unsigned cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard entries: {overrun, data1, data0}
  logic [24:0] exp_q[$];

  // ADC model: MSB presented when CS falls, next bit after each SCLK rise.
  logic [15:0] adc_word0 = 16'h0, adc_word1 = 16'h0;
  logic [15:0] cur0 = 16'h0, cur1 = 16'h0;
  always @(negedge cs_n) begin
    cur0 = adc_word0;
    cur1 = adc_word1;
    #1;
    sdata0 = cur0[15];
    sdata1 = cur1[15];
  end
  always @(posedge sclk) begin
    if (!cs_n) begin
      cur0 = {cur0[14:0], 1'b0};
      cur1 = {cur1[14:0], 1'b0};
      #1;
      sdata0 = cur0[15];
      sdata1 = cur1[15];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: frame timing plus scoreboard comparison one cycle after the DONE cycle
  initial begin : monitor
    int low_cnt;
    int rises;
    logic prev_cs;
    logic prev_sclk;
    logic [24:0] e;
    low_cnt = 0;
    rises = 0;
    prev_cs = 1'b1;
    prev_sclk = 1'b1;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        low_cnt = 0;
        rises = 0;
      end else if (!cs_n) begin
        low_cnt++;
        if (sclk && !prev_sclk) rises++;
      end else if (!prev_cs) begin
        check("cs_low_cycles", low_cnt, LOW_CYCLES);
        check("sclk_rises", rises, 16);
        low_cnt = 0;
        rises = 0;
        @(negedge ACLK);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h/%0h required=none", data0, data1);
        end else begin
          e = exp_q.pop_front();
          check("data0", data0, e[11:0]);
          check("data1", data1, e[23:12]);
          check("overrun_at_load", overrun, e[24]);
          check("data_valid_at_load", data_valid, 1);
        end
      end
      prev_cs = cs_n;
      prev_sclk = sclk;
    end
  end

  // driver tasks (all entered and left at a falling ACLK edge)
  task automatic wait_cs(input logic level, input int max_cyc, input string name);
    int n = 0;
    while (cs_n !== level && n < max_cyc) begin
      @(negedge ACLK);
      n++;
    end
    check(name, cs_n, level);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      @(negedge ACLK);
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    @(negedge ACLK);
    rd_ack = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] w0, input logic [15:0] w1,
                           input logic ovr, input logic ack_in_done);
    wait_idle(300);
    adc_word0 = w0;
    adc_word1 = w1;
    exp_q.push_back({ovr, w1[11:0], w0[11:0]});
    pulse_start();
    wait_cs(1'b0, 50, "cs_fall");
    wait_cs(1'b1, 200, "cs_rise");
    if (ack_in_done) rd_ack = 1'b1;
    @(negedge ACLK);
    rd_ack = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int unsigned t_prev;
    int n_low;
    int n_rise;
    logic prev_s;
    logic [15:0] w0s[3];
    logic [15:0] w1s[3];
    w0s[0] = 16'h0111; w0s[1] = 16'h0222; w0s[2] = 16'h0333;
    w1s[0] = 16'h0444; w1s[1] = 16'h0555; w1s[2] = 16'h0666;
    t_prev = 0;

    // reset state
    repeat (3) @(negedge ACLK);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_data0", data0, 0);
    check("rst_data1", data1, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    // 1: single-shot frame
    run_frame(16'h0ABC, 16'h0123, 1'b0, 1'b0);
    check("t1_valid", data_valid, 1);
    check("t1_overrun", overrun, 0);
    pulse_ack();
    check("t1_ack_clears_valid", data_valid, 0);

    // 2: continuous mode, three frames, ack after each
    wait_idle(300);
    adc_word0 = w0s[0];
    adc_word1 = w1s[0];
    exp_q.push_back({1'b0, w1s[0][11:0], w0s[0][11:0]});
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_cs(1'b0, 300, "t2_cs_fall");
      if (k == 2) begin
        enable = 1'b0;
      end else begin
        adc_word0 = w0s[k+1];
        adc_word1 = w1s[k+1];
        exp_q.push_back({1'b0, w1s[k+1][11:0], w0s[k+1][11:0]});
      end
      wait_cs(1'b1, 200, "t2_cs_rise");
      if (k > 0) check("t2_frame_period", cyc - t_prev, PERIOD);
      t_prev = cyc;
      @(negedge ACLK);
      @(negedge ACLK);
      pulse_ack();
    end
    wait_idle(300);
    check("t2_overrun", overrun, 0);

    // 3: two unread frames produce overrun; clr_overrun clears it
    run_frame(16'h0AAA, 16'h0CCC, 1'b0, 1'b0);
    run_frame(16'h0555, 16'h0333, 1'b1, 1'b0);
    check("t3_data0", data0, 12'h555);
    clr_overrun = 1'b1;
    @(negedge ACLK);
    clr_overrun = 1'b0;
    check("t3_overrun_cleared", overrun, 0);
    check("t3_valid_kept", data_valid, 1);

    // 4: rd_ack in the DONE cycle of the second frame
    pulse_ack();
    run_frame(16'h0246, 16'h0135, 1'b0, 1'b0);
    run_frame(16'h0F0F, 16'h0777, 1'b0, 1'b1);
    @(negedge ACLK);
    check("t4_valid", data_valid, 1);
    check("t4_overrun", overrun, 0);

    // 5: reset 50 cycles into SHIFT aborts the frame
    wait_idle(300);
    adc_word0 = 16'h0FA5;
    adc_word1 = 16'h05AF;
    pulse_start();
    wait_cs(1'b0, 50, "t5_cs_fall");
    repeat (CLK_DIV + 50) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("t5_cs_n", cs_n, 1);
    check("t5_sclk", sclk, 1);
    check("t5_busy", busy, 0);
    check("t5_valid", data_valid, 0);
    check("t5_data0", data0, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    n_low = 0;
    n_rise = 0;
    prev_s = sclk;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (!cs_n) n_low++;
      if (sclk && !prev_s) n_rise++;
      prev_s = sclk;
    end
    check("t5_no_sclk_edges", n_rise, 0);
    check("t5_cs_stays_high", n_low, 0);

    // 6: all-ones frame, then a start pulse during QUIET is ignored
    run_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    check("t6_in_quiet_busy", busy, 1);
    pulse_start();
    n_low = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ACLK);
      if (!cs_n) n_low++;
    end
    check("t6_no_second_frame", n_low, 0);
    check("t6_busy", busy, 0);
    check("t6_data1", data1, 12'hFFF);

    repeat (5) @(negedge ACLK);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmod_ad1_spi_capture.md
Name: pmod_ad1_spi_capture

Overview:
- SPI capture engine for the Digilent PMOD AD1 (two AD7476A 12-bit ADCs sharing CS and SCLK, separate data lines D0/D1).
- Generates CS/SCLK, shifts in both channels simultaneously, and publishes a 12-bit sample pair with valid/ack handshake.
- Sits directly upstream of the PMOD_AD1 AXI4-Lite slave register file, which reads data0/data1/status and pulses rd_ack.
- Runs in single-shot (start pulse) or continuous (enable level) mode.

Parameters:
CLK_DIV, 4, ACLK cycles per SCLK half-period; legal range 3..255
QUIET_CYCLES, 8, ACLK cycles CS held high between conversions; legal range 1..255

Ports:
ACLK  in  1  system clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
enable  in  1  continuous conversion mode while high
start  in  1  single-cycle pulse, one conversion; ignored while busy
rd_ack  in  1  consumer pulse: current result read, clears data_valid
clr_overrun  in  1  pulse, clears overrun
sdata0  in  1  ADC channel 0 serial data (async pad)
sdata1  in  1  ADC channel 1 serial data (async pad)
cs_n  out  1  ADC chip select, active low
sclk  out  1  ADC serial clock, idle high
data0  out  12  channel 0 result, unsigned
data1  out  12  channel 1 result, unsigned
data_valid  out  1  unread result present
overrun  out  1  sticky: result overwritten while unread
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: cs_n=1, sclk=1, data0=data1=0, data_valid=0, overrun=0, busy=0, FSM=IDLE, counters cleared. Reset mid-conversion aborts immediately with no result published.
- sdata0/sdata1 pass through 2-flop synchronisers before sampling.
- FSM states: IDLE, SETUP, SHIFT, DONE, QUIET.
- IDLE: cs_n=1, sclk=1. Go to SETUP if start=1 or enable=1.
- SETUP: cs_n=0, sclk=1 for CLK_DIV cycles, then go to SHIFT.
- SHIFT: 16 bit periods. Each period is sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - Synchronised sdata0/sdata1 are shifted in MSB first on the ACLK edge where sclk goes 0->1.
  - After the 16th high phase, go to DONE.
- Timing: cs_n low for exactly CLK_DIV + 32*CLK_DIV cycles, which is 132 at default. Exactly 16 sclk rising edges per frame.
- DONE (1 cycle): cs_n=1. data0/data1 load shift-register bits [11:0]; the 4 leading bits are discarded. data_valid set.
  - If data_valid was already 1 and rd_ack is not present this cycle, set overrun.
  - Load always takes the newest sample.
- QUIET: cs_n=1, sclk=1 for QUIET_CYCLES cycles.
  - Then go to SETUP if enable=1, otherwise IDLE.
  - A start pulse received during QUIET is ignored.
- Continuous-mode frame period: 1 + 33*CLK_DIV + 1 + QUIET_CYCLES, which is 142 at default.
- Handshake:
  - rd_ack clears data_valid next cycle.
  - rd_ack in the same cycle as a DONE load: load wins, data_valid stays 1, overrun not set.
  - rd_ack with data_valid=0 has no effect.
- clr_overrun clears overrun next cycle. If clr_overrun coincides with a new overrun event, overrun stays 1.
- start and enable dropping mid-frame do not abort the frame; the current frame always completes.
- Bit and period counters must not wrap within a frame. The SHIFT bit counter is 5 bits and terminates at 16.

Test Plan:
1. Bench ADC model drives 0x0ABC on D0 and 0x0123 on D1; single start pulse -> cs_n low 132 cycles, 16 sclk rising edges, data0=0xABC, data1=0x123, data_valid=1, overrun=0.
2. enable=1 for 3 frames with models 0x0111/0x0222/0x0333, rd_ack after each -> cs_n rising edges 142 cycles apart, data0 sequence 0x111, 0x222, 0x333, overrun=0.
3. Two frames with no rd_ack (0x0AAA, then 0x0555) -> overrun=1 after 2nd DONE, data0=0x555; clr_overrun -> overrun=0 next cycle, data_valid still 1.
4. rd_ack asserted exactly in the DONE cycle of the 2nd frame -> data_valid remains 1, overrun=0.
5. ARESET asserted 50 cycles into SHIFT -> next cycle cs_n=1, sclk=1, busy=0, data_valid=0, data0=0; no further sclk edges.
6. Model drives 0xFFFF on both lines, then a start pulse during QUIET -> data0=data1=0xFFF; the start pulse in QUIET does not trigger a second frame.
